mod_exp_controller: RTL and testbench
=====================================

MOD_EXP_CONTROLLER -- requirements
Module: mod_exp_controller

Interface
REQ-001 Parameter WIDTH, default 16, operand/modulus/result width in bits.
REQ-002 Parameter EXP_WIDTH, default 16, exponent width in bits.
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 ready_in  input  1  start request; sampled only in IDLE.
REQ-006 base_in, exponent_in, modulus_in  input  WIDTH, EXP_WIDTH, WIDTH  operands; captured on accepted start.
REQ-007 value_out  output  WIDTH  result base^exponent mod modulus; held until the next result or reset.
REQ-008 busy_out  output  1  high from the cycle after start acceptance until the result is written.
REQ-009 valid_out  output  1  one-cycle pulse on the cycle busy_out falls.
REQ-010 mod_ready_out  output  1  one-cycle issue pulse to the shared modulus unit.
REQ-011 mod_value_out, mod_modulus_out  output  2*WIDTH each  dividend and zero-extended modulus; stable from issue until mod_valid_in.
REQ-012 mod_value_in  input  2*WIDTH  remainder from the modulus unit; only bits [WIDTH-1:0] are used.
REQ-013 mod_busy_in, mod_valid_in  input  1 each  modulus unit busy level and one-cycle completion pulse.

Function
REQ-014 Algorithm: right-to-left square-and-multiply; registers acc (WIDTH, init 1), b (WIDTH), e (EXP_WIDTH).
REQ-015 States: IDLE, BASE_ISSUE, BASE_WAIT, CHECK, MUL_ISSUE, MUL_WAIT, SQR_ISSUE, SQR_WAIT, DONE.
REQ-016 IDLE: on ready_in=1, capture operands, set acc=1, assert busy_out next cycle, go to BASE_ISSUE; if modulus_in==0 or 1, go directly to DONE with acc=0.
REQ-017 BASE_ISSUE: once mod_busy_in=0, pulse mod_ready_out with mod_value_out={0,base}, go to BASE_WAIT.
REQ-018 Every *_ISSUE state waits with mod_ready_out=0 while mod_busy_in=1; only one request is outstanding at a time.
REQ-019 BASE_WAIT: on mod_valid_in, b = mod_value_in[WIDTH-1:0], go to CHECK.
REQ-020 CHECK: if e==0, go to DONE; else if e[0]==1, go to MUL_ISSUE; else go to SQR_ISSUE.
REQ-021 MUL_ISSUE sends mod_value_out = acc*b as a full 2*WIDTH product; on mod_valid_in in MUL_WAIT, set acc = the result.
REQ-022 After MUL_WAIT: shift e right by 1; if the new e==0, go to DONE, else go to SQR_ISSUE.
REQ-023 On an even-bit path (entered from CHECK with e[0]==0), shift e right by 1 at SQR_ISSUE entry.
REQ-024 SQR_ISSUE sends b*b; on mod_valid_in in SQR_WAIT, set b = the result and go to CHECK.
REQ-025 No square is issued once the remaining e==0.
REQ-026 Number of mod_ready_out pulses = 1 + popcount(exponent) + (index of the highest set bit of exponent), or 1 when exponent==0.
REQ-027 DONE (one cycle): value_out=acc, busy_out=0, valid_out=1, go to IDLE.
REQ-028 ready_in asserted while busy_out=1 is ignored and has no side effects.
REQ-029 mod_value_in is ignored when mod_valid_in=0 or when in a non-WAIT state.
REQ-030 Products are computed at 2*WIDTH width with no truncation before reduction.

Reset
REQ-031 rst_in=1 in any state forces IDLE and zeroes value_out, busy_out, valid_out, mod_ready_out, mod_value_out, mod_modulus_out, acc, b and e on the next edge.
REQ-032 Reset mid-operation abandons the computation; no valid_out pulse is produced.
REQ-033 The modulus unit shares rst_in; a completion pulse arriving after reset is discarded.

Verification
REQ-034 base=4, exp=13, mod=497 -> value_out=445; exactly 7 mod_ready_out pulses; single valid_out pulse.
REQ-035 base=2, exp=10, mod=1000 -> 24; base=3, exp=200, mod=50 -> 1.
REQ-036 base=1000, exp=1, mod=7 -> 6 (base>=mod); base=5, exp=0, mod=7 -> 1 after exactly 1 mod_ready_out pulse.
REQ-037 mod=0 or mod=1, any base/exp -> value_out=0 with no mod_ready_out pulses; valid_out 2 cycles after ready_in.
REQ-038 Model the modulus unit with mod_busy_in held high 5 extra cycles before accepting each request -> no mod_ready_out while busy; operands stay stable until mod_valid_in.
REQ-039 Run 4^13 mod 497, pulse ready_in mid-run with other operands, then assert rst_in during MUL_WAIT -> start is ignored, no valid_out follows, all outputs are 0, and a fresh start computes correctly.

Source files
------------

// File: rtl/mod_exp_controller_if.sv
// rtl/mod_exp_controller_if.sv - request/response bus to the shared modulus unit
// Ports (controller view, modport master):
//   mod_ready_out    out  1        one-cycle request pulse
//   mod_value_out    out  2*WIDTH  dividend, stable until mod_valid_in
//   mod_modulus_out  out  2*WIDTH  zero-extended modulus
//   mod_value_in     in   2*WIDTH  remainder (low WIDTH bits meaningful)
//   mod_busy_in      in   1        unit busy level
//   mod_valid_in     in   1        one-cycle completion pulse
interface mod_exp_controller_if #(
  parameter int WIDTH = 16
);
  logic               mod_ready_out;
  logic [2*WIDTH-1:0] mod_value_out;
  logic [2*WIDTH-1:0] mod_modulus_out;
  logic [2*WIDTH-1:0] mod_value_in;
  logic               mod_busy_in;
  logic               mod_valid_in;

  modport master (
    output mod_ready_out, mod_value_out, mod_modulus_out,
    input  mod_value_in, mod_busy_in, mod_valid_in
  );

  modport slave (
    input  mod_ready_out, mod_value_out, mod_modulus_out,
    output mod_value_in, mod_busy_in, mod_valid_in
  );
endinterface

// File: rtl/mod_exp_controller.sv
// rtl/mod_exp_controller.sv - right-to-left square-and-multiply modular exponentiation sequencer
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   ready_in              start request, sampled only in IDLE
//   base_in/exponent_in/modulus_in  operands captured on accepted start
//   value_out             result, held until next result or reset
//   busy_out, valid_out   operation in progress / one-cycle result strobe
//   mod_bus               master side of the shared modulus unit bus
module mod_exp_controller #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 ready_in,
  input  logic [WIDTH-1:0]     base_in,
  input  logic [EXP_WIDTH-1:0] exponent_in,
  input  logic [WIDTH-1:0]     modulus_in,
  output logic [WIDTH-1:0]     value_out,
  output logic                 busy_out,
  output logic                 valid_out,
  mod_exp_controller_if.master mod_bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_BASE_ISSUE, S_BASE_WAIT, S_CHECK, S_MUL_ISSUE,
    S_MUL_WAIT, S_SQR_ISSUE, S_SQR_WAIT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [EXP_WIDTH-1:0] e_q, e_d;
  logic [WIDTH-1:0]     value_q, value_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic                 mreq_q, mreq_d;
  logic [2*WIDTH-1:0]   mval_q, mval_d;
  logic [2*WIDTH-1:0]   mmod_q, mmod_d;

  // Zero-extended copies so products keep all 2*WIDTH bits before reduction.
  logic [2*WIDTH-1:0] acc_w, b_w;
  logic [WIDTH-1:0]   rem;
  logic               unused_rem_hi;

  assign acc_w         = {{WIDTH{1'b0}}, acc_q};
  assign b_w           = {{WIDTH{1'b0}}, b_q};
  assign rem           = mod_bus.mod_value_in[WIDTH-1:0];
  assign unused_rem_hi = ^mod_bus.mod_value_in[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    e_d     = e_q;
    value_d = value_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    mreq_d  = 1'b0;
    mval_d  = mval_q;
    mmod_d  = mmod_q;
    case (state_q)
      S_IDLE: begin
        if (ready_in) begin
          // b holds the raw base until the first reduction returns.
          b_d    = base_in;
          e_d    = exponent_in;
          mmod_d = {{WIDTH{1'b0}}, modulus_in};
          busy_d = 1'b1;
          if (modulus_in[WIDTH-1:1] == '0) begin
            acc_d   = '0;
            state_d = S_DONE;
          end else begin
            acc_d   = {{(WIDTH-1){1'b0}}, 1'b1};
            state_d = S_BASE_ISSUE;
          end
        end
      end
      S_BASE_ISSUE: begin
        if (!mod_bus.mod_busy_in) begin
          mreq_d  = 1'b1;
          mval_d  = b_w;
          state_d = S_BASE_WAIT;
        end
      end
      S_BASE_WAIT: begin
        if (mod_bus.mod_valid_in) begin
          b_d     = rem;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (e_q == '0) begin
          state_d = S_DONE;
        end else if (e_q[0]) begin
          state_d = S_MUL_ISSUE;
        end else begin
          // Even bit: nothing to multiply, consume it on the way to the square.
          e_d     = e_q >> 1;
          state_d = S_SQR_ISSUE;
        end
      end
      S_MUL_ISSUE: begin
        if (!mod_bus.mod_busy_in) begin
          mreq_d  = 1'b1;
          mval_d  = acc_w * b_w;
          state_d = S_MUL_WAIT;
        end
      end
      S_MUL_WAIT: begin
        if (mod_bus.mod_valid_in) begin
          acc_d = rem;
          e_d   = e_q >> 1;
          // Last set bit consumed: the square would be wasted work.
          state_d = ((e_q >> 1) == '0) ? S_DONE : S_SQR_ISSUE;
        end
      end
      S_SQR_ISSUE: begin
        if (!mod_bus.mod_busy_in) begin
          mreq_d  = 1'b1;
          mval_d  = b_w * b_w;
          state_d = S_SQR_WAIT;
        end
      end
      S_SQR_WAIT: begin
        if (mod_bus.mod_valid_in) begin
          b_d     = rem;
          state_d = S_CHECK;
        end
      end
      S_DONE: begin
        value_d = acc_q;
        busy_d  = 1'b0;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      e_q     <= '0;
      value_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      mreq_q  <= 1'b0;
      mval_q  <= '0;
      mmod_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      e_q     <= e_d;
      value_q <= value_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      mreq_q  <= mreq_d;
      mval_q  <= mval_d;
      mmod_q  <= mmod_d;
    end
  end

  assign value_out               = value_q;
  assign busy_out                = busy_q;
  assign valid_out               = valid_q;
  assign mod_bus.mod_ready_out   = mreq_q;
  assign mod_bus.mod_value_out   = mval_q;
  assign mod_bus.mod_modulus_out = mmod_q;

endmodule

// File: tb/tb_mod_exp_controller.sv
// tb/tb_mod_exp_controller.sv - self-checking bench for mod_exp_controller with a modulus unit model
module tb_mod_exp_controller;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready_in = 1'b0;
  logic [W-1:0]  base_in = '0;
  logic [W-1:0]  exponent_in = '0;
  logic [W-1:0]  modulus_in = '0;
  logic [W-1:0]  value_out;
  logic          busy_out;
  logic          valid_out;

  mod_exp_controller_if #(.WIDTH(W)) mbus ();

  mod_exp_controller #(.WIDTH(W), .EXP_WIDTH(W)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .ready_in    (ready_in),
    .base_in     (base_in),
    .exponent_in (exponent_in),
    .modulus_in  (modulus_in),
    .value_out   (value_out),
    .busy_out    (busy_out),
    .valid_out   (valid_out),
    .mod_bus     (mbus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Modulus unit model: fixed latency, optional busy hold-off after each result.
  int          lat = 3;
  int          stall = 0;
  bit          pending = 1'b0;
  int          cnt = 0;
  int          post = 0;
  logic [31:0] req_val = '0;
  logic [31:0] req_mod = 32'd1;

  always @(posedge clk) begin
    if (rst) begin
      mbus.mod_busy_in  <= 1'b0;
      mbus.mod_valid_in <= 1'b0;
      mbus.mod_value_in <= '0;
      pending <= 1'b0;
      cnt     <= 0;
      post    <= 0;
    end else begin
      mbus.mod_valid_in <= 1'b0;
      if (pending) begin
        if (cnt <= 1) begin
          mbus.mod_valid_in <= 1'b1;
          mbus.mod_value_in <= req_val % req_mod;
          pending <= 1'b0;
          post    <= stall;
          if (stall == 0) mbus.mod_busy_in <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end else if (post > 0) begin
        post <= post - 1;
        if (post == 1) mbus.mod_busy_in <= 1'b0;
      end else if (mbus.mod_ready_out === 1'b1) begin
        pending <= 1'b1;
        req_val <= mbus.mod_value_out;
        req_mod <= mbus.mod_modulus_out;
        cnt     <= lat;
        mbus.mod_busy_in <= 1'b1;
      end
    end
  end

  // Monitor, sampled away from the active edge.
  int rdy_cnt = 0;
  int val_cnt = 0;
  int busy_viol = 0;
  int stab_viol = 0;

  always @(negedge clk) begin
    if (mbus.mod_ready_out === 1'b1) rdy_cnt++;
    if (valid_out === 1'b1) val_cnt++;
    if (mbus.mod_ready_out === 1'b1 && mbus.mod_busy_in !== 1'b0) busy_viol++;
    if (pending && (mbus.mod_value_out !== req_val || mbus.mod_modulus_out !== req_mod)) stab_viol++;
  end

  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                        output logic [W-1:0] res, output int pulses, output int valids,
                        output bit timeout);
    int p0;
    int v0;
    @(negedge clk);
    p0 = rdy_cnt;
    v0 = val_cnt;
    base_in = b; exponent_in = e; modulus_in = m; ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    timeout = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (val_cnt != v0) begin
        timeout = 1'b0;
        break;
      end
    end
    repeat (10) @(negedge clk);
    res    = value_out;
    pulses = rdy_cnt - p0;
    valids = val_cnt - v0;
  endtask

  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] e;
    logic [W-1:0] m;
    int           stall;
    logic [W-1:0] exp_val;
    int           exp_pulses;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [W-1:0] res;
    int  pulses, valids, p0, v0;
    bit  to;

    vecs[0]  = '{b:4,     e:13,  m:497,   stall:0, exp_val:445,  exp_pulses:7};
    vecs[1]  = '{b:2,     e:10,  m:1000,  stall:0, exp_val:24,   exp_pulses:6};
    vecs[2]  = '{b:3,     e:200, m:50,    stall:0, exp_val:1,    exp_pulses:11};
    vecs[3]  = '{b:1000,  e:1,   m:7,     stall:0, exp_val:6,    exp_pulses:2};
    vecs[4]  = '{b:5,     e:0,   m:7,     stall:0, exp_val:1,    exp_pulses:1};
    vecs[5]  = '{b:9,     e:7,   m:0,     stall:0, exp_val:0,    exp_pulses:0};
    vecs[6]  = '{b:9,     e:7,   m:1,     stall:0, exp_val:0,    exp_pulses:0};
    vecs[7]  = '{b:7,     e:3,   m:11,    stall:0, exp_val:2,    exp_pulses:4};
    vecs[8]  = '{b:60000, e:3,   m:65000, stall:0, exp_val:5000, exp_pulses:4};
    vecs[9]  = '{b:4,     e:13,  m:497,   stall:5, exp_val:445,  exp_pulses:7};
    vecs[10] = '{b:2,     e:10,  m:1000,  stall:5, exp_val:24,   exp_pulses:6};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset value_out", 32'(value_out), 0);
    check("reset busy_out", 32'(busy_out), 0);
    check("reset valid_out", 32'(valid_out), 0);
    check("reset mod_ready_out", 32'(mbus.mod_ready_out), 0);
    check("reset mod_value_out", mbus.mod_value_out, 0);
    check("reset mod_modulus_out", mbus.mod_modulus_out, 0);

    for (int i = 0; i < 11; i++) begin
      stall = vecs[i].stall;
      run_op(vecs[i].b, vecs[i].e, vecs[i].m, res, pulses, valids, to);
      check($sformatf("vec%0d timeout", i), 32'(to), 0);
      check($sformatf("vec%0d value", i), 32'(res), 32'(vecs[i].exp_val));
      check($sformatf("vec%0d pulses", i), pulses, vecs[i].exp_pulses);
      check($sformatf("vec%0d valid count", i), valids, 1);
      check($sformatf("vec%0d busy after", i), 32'(busy_out), 0);
    end
    stall = 0;

    // Degenerate modulus: result strobe two cycles after the start request.
    @(negedge clk);
    p0 = rdy_cnt;
    base_in = 16'd123; exponent_in = 16'd45; modulus_in = 16'd1; ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    check("mod1 cycle1 valid", 32'(valid_out), 0);
    check("mod1 cycle1 busy", 32'(busy_out), 1);
    @(negedge clk);
    check("mod1 cycle2 valid", 32'(valid_out), 1);
    check("mod1 cycle2 busy", 32'(busy_out), 0);
    check("mod1 cycle2 value", 32'(value_out), 0);
    @(negedge clk);
    check("mod1 cycle3 valid", 32'(valid_out), 0);
    check("mod1 pulses", rdy_cnt - p0, 0);

    // Mid-run start request is ignored, then reset during MUL_WAIT abandons the run.
    lat = 10;
    @(negedge clk);
    p0 = rdy_cnt;
    v0 = val_cnt;
    base_in = 16'd4; exponent_in = 16'd13; modulus_in = 16'd497; ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (rdy_cnt - p0 >= 2) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("midrun reach mul timeout", 32'(to), 0);
    base_in = 16'd9; exponent_in = 16'd2; modulus_in = 16'd123; ready_in = 1'b1;
    @(negedge clk);
    ready_in = 1'b0;
    check("midrun modulus kept", mbus.mod_modulus_out, 497);
    check("midrun mul operand kept", mbus.mod_value_out, 4);
    check("midrun busy", 32'(busy_out), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst value_out", 32'(value_out), 0);
    check("midrst busy_out", 32'(busy_out), 0);
    check("midrst valid_out", 32'(valid_out), 0);
    check("midrst mod_ready_out", 32'(mbus.mod_ready_out), 0);
    check("midrst mod_value_out", mbus.mod_value_out, 0);
    check("midrst mod_modulus_out", mbus.mod_modulus_out, 0);
    repeat (30) @(negedge clk);
    check("midrst no valid", val_cnt - v0, 0);
    check("midrst pulses", rdy_cnt - p0, 2);
    lat = 3;
    run_op(16'd2, 16'd10, 16'd1000, res, pulses, valids, to);
    check("fresh timeout", 32'(to), 0);
    check("fresh value", 32'(res), 24);
    check("fresh pulses", pulses, 6);
    check("fresh valid count", valids, 1);

    check("issue while busy", busy_viol, 0);
    check("operand stability", stab_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
